enable_sequencer: RTL and testbench

- Sits directly downstream of `comm`. It consumes the 16-bit `enabled_out` mask and drives the physical per-console enable lines.
- It applies every mask change break-before-make:
  - All channels being switched off are dropped together.
  - After a guard interval, newly enabled channels are switched on one at a time, lowest index first, spaced by a stagger interval.
- Purpose: two consoles are never briefly connected at once, and inrush on the console transceivers is limited.

---
 rtl/enable_sequencer.sv | 103 ++++++++++
 tb/tb_enable_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/enable_sequencer.sv
// Break-before-make sequencer for the per-console enable lines: drops all removed
// channels at once, waits a guard interval, then enables new channels one by one.
module enable_sequencer #(
    parameter int WIDTH          = 16,
    parameter int GUARD_CYCLES   = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] mask_in,
    output logic [WIDTH-1:0] enables_out,
    output logic             busy,
    output logic             done
);

    localparam int MAX_CYCLES = (GUARD_CYCLES > STAGGER_CYCLES) ? GUARD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GUARD_INIT   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_INIT = CNT_W'(STAGGER_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GUARD, MAKE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] target, target_next;
    logic [WIDTH-1:0] enables_next;
    logic [WIDTH-1:0] pending;
    logic             done_next;

    // Isolates the lowest set bit so only one channel turns on per edge.
    function automatic logic [WIDTH-1:0] lowest_bit(input logic [WIDTH-1:0] v);
        return v & (~v + WIDTH'(1));
    endfunction

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        target_next  = target;
        enables_next = enables_out;
        done_next    = 1'b0;
        pending      = target & ~enables_out;
        case (state)
            IDLE: begin
                if (mask_in != enables_out) begin
                    target_next = mask_in;
                    if ((enables_out & ~mask_in) != '0) begin
                        enables_next = enables_out & mask_in;
                        cnt_next     = GUARD_INIT;
                        state_next   = GUARD;
                    end else begin
                        cnt_next   = '0;
                        state_next = MAKE;
                    end
                end
            end
            GUARD: begin
                if (cnt == '0) begin
                    cnt_next   = '0;
                    state_next = MAKE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            MAKE: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else if (pending != '0) begin
                    enables_next = enables_out | lowest_bit(pending);
                    cnt_next     = STAGGER_INIT;
                end else begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            enables_out <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            enables_out <= enables_next;
            busy        <= (state_next != IDLE);
            done        <= done_next;
        end
    end

    // The latched request only matters after IDLE loads it, so it needs no reset.
    always_ff @(posedge clk) begin
        target <= target_next;
    end

endmodule

// File: tb/tb_enable_sequencer.sv
// Bench for enable_sequencer: a timeline model of each sequence is compared every
// cycle, alongside hand-computed expectations for the directed scenarios.
module tb_enable_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mask_in = 16'hFFFF;
    logic [15:0] mask_s1 = 16'hFFFF;
    logic [15:0] en0, en1;
    logic        busy0, busy1, done0, done1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    enable_sequencer #(.WIDTH(16), .GUARD_CYCLES(16), .STAGGER_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .mask_in(mask_in),
        .enables_out(en0), .busy(busy0), .done(done0));

    enable_sequencer #(.WIDTH(16), .GUARD_CYCLES(16), .STAGGER_CYCLES(1)) dut_s1 (
        .clk(clk), .rst(rst), .mask_in(mask_s1),
        .enables_out(en1), .busy(busy1), .done(done1));

    // Sequence model: a change seen at edge 0 breaks at once; makes start at edge
    // GUARD+1 (or 1 without a break) and repeat every STAGGER edges; done follows
    // one STAGGER after the last make (or at the first make slot if none).
    typedef struct packed {
        logic [15:0] en;
        logic [15:0] tgt;
        logic        busy;
        logic        done;
        logic        active;
        int          e;
        int          s;
        int          last;
    } model_t;

    model_t m0, m1;

    function automatic logic [15:0] low_bit(input logic [15:0] v);
        logic [15:0] r = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) r = 16'(1) << i;
        return r;
    endfunction

    function automatic model_t step(input model_t m, input logic [15:0] mask,
                                    input int guard, input int stagger);
        model_t n = m;
        n.done = 1'b0;
        if (!m.active) begin
            if (mask != m.en) begin
                n.active = 1'b1;
                n.busy   = 1'b1;
                n.e      = 0;
                n.tgt    = mask;
                n.s      = ((m.en & ~mask) != 0) ? guard + 1 : 1;
                n.en     = m.en & mask;
                n.last   = n.s + $countones(mask & ~n.en) * stagger;
            end
        end else begin
            n.e = m.e + 1;
            if (n.e >= n.s && n.e < n.last && ((n.e - n.s) % stagger) == 0)
                n.en = m.en | low_bit(m.tgt & ~m.en);
            if (n.e == n.last) begin
                n.active = 1'b0;
                n.busy   = 1'b0;
                n.done   = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 <= '0;
            m1 <= '0;
        end else begin
            m0 <= step(m0, mask_in, 16, 4);
            m1 <= step(m1, mask_s1, 16, 1);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            check("model.en",   32'(en0),   32'(m0.en));
            check("model.busy", 32'(busy0), 32'(m0.busy));
            check("model.done", 32'(done0), 32'(m0.done));
            check("model_s1.en",   32'(en1),   32'(m1.en));
            check("model_s1.busy", 32'(busy1), 32'(m1.busy));
            check("model_s1.done", 32'(done1), 32'(m1.done));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset with all channels requested
        ticks(3);
        check("rst.en", 32'(en0), 32'h0);
        check("rst.busy", 32'(busy0), 32'h0);
        check("rst.done", 32'(done0), 32'h0);
        mask_in = 16'h0000;
        mask_s1 = 16'h0000;
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle.en", 32'(en0), 32'h0);
            check("idle.busy", 32'(busy0), 32'h0);
        end

        // Make only: 0x0000 -> 0x0003
        mask_in = 16'h0003;
        tick();    check("mk.e0.busy", 32'(busy0), 32'h1);
                   check("mk.e0.en", 32'(en0), 32'h0);
        tick();    check("mk.e1.en", 32'(en0), 32'h1);
        ticks(3);  check("mk.e4.en", 32'(en0), 32'h1);
        tick();    check("mk.e5.en", 32'(en0), 32'h3);
        ticks(3);  check("mk.e8.done", 32'(done0), 32'h0);
                   check("mk.e8.busy", 32'(busy0), 32'h1);
        tick();    check("mk.e9.done", 32'(done0), 32'h1);
                   check("mk.e9.busy", 32'(busy0), 32'h0);
        tick();    check("mk.e10.done", 32'(done0), 32'h0);

        // Break then make: 0x0003 -> 0x000C
        mask_in = 16'h000C;
        tick();    check("bm.e0.en", 32'(en0), 32'h0);
                   check("bm.e0.busy", 32'(busy0), 32'h1);
        ticks(16); check("bm.e16.en", 32'(en0), 32'h0);
        tick();    check("bm.e17.en", 32'(en0), 32'h4);
        ticks(4);  check("bm.e21.en", 32'(en0), 32'hC);
        ticks(4);  check("bm.e25.done", 32'(done0), 32'h1);

        // Break only: 0x00FF -> 0x000F
        mask_in = 16'h00FF;
        ticks(30); check("bo.pre.en", 32'(en0), 32'hFF);
                   check("bo.pre.busy", 32'(busy0), 32'h0);
        mask_in = 16'h000F;
        tick();    check("bo.e0.en", 32'(en0), 32'hF);
                   check("bo.e0.busy", 32'(busy0), 32'h1);
        ticks(16); check("bo.e16.done", 32'(done0), 32'h0);
                   check("bo.e16.en", 32'(en0), 32'hF);
        tick();    check("bo.e17.done", 32'(done0), 32'h1);
                   check("bo.e17.busy", 32'(busy0), 32'h0);
        tick();    check("bo.e18.done", 32'(done0), 32'h0);

        // Mid-sequence request change is deferred until the sequence ends
        mask_in = 16'h0000;
        ticks(20); check("mid.pre.en", 32'(en0), 32'h0);
        mask_in = 16'h0003;
        ticks(3);  check("mid.e2.en", 32'(en0), 32'h1);
        mask_in = 16'h0010;
        ticks(3);  check("mid.e5.en", 32'(en0), 32'h3);
        ticks(4);  check("mid.e9.done", 32'(done0), 32'h1);
                   check("mid.e9.en", 32'(en0), 32'h3);
        tick();    check("mid.e10.en", 32'(en0), 32'h0);
                   check("mid.e10.busy", 32'(busy0), 32'h1);
        ticks(17); check("mid.e27.en", 32'(en0), 32'h10);
        ticks(4);  check("mid.e31.done", 32'(done0), 32'h1);

        // Asynchronous reset during GUARD
        mask_in = 16'h8000;
        tick();    check("ar.e0.en", 32'(en0), 32'h0);
                   check("ar.e0.busy", 32'(busy0), 32'h1);
        ticks(3);
        #1 rst = 1'b1;
        #1 check("ar.rst.en", 32'(en0), 32'h0);
           check("ar.rst.busy", 32'(busy0), 32'h0);
           check("ar.rst.done", 32'(done0), 32'h0);
        #1 rst = 1'b0;
        tick();    check("ar.e0b.busy", 32'(busy0), 32'h1);
                   check("ar.e0b.en", 32'(en0), 32'h0);
        tick();    check("ar.e1b.en", 32'(en0), 32'h8000);
        ticks(4);  check("ar.e5b.done", 32'(done0), 32'h1);

        // Single-cycle stagger: one new bit per edge, lowest first
        mask_s1 = 16'hFFFF;
        tick();    check("s1.e0.en", 32'(en1), 32'h0);
                   check("s1.e0.busy", 32'(busy1), 32'h1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("s1.step.en", 32'(en1), (32'h1 << k) - 32'h1);
        end
        tick();    check("s1.e17.done", 32'(done1), 32'h1);
        ticks(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
